fifo_flags: RTL and testbench
=============================

# fifo_flags

Synchronous single-clock FIFO, the parametrised successor to the team's basic pointer-based FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It uses its own internal storage array, sits between a producer and consumer on the same clock, and drops in wherever the basic FIFO is used today.

## Interface

- DATA_SIZE, 8: word width in bits.
- ADDR_WIDTH, 4: address bits; DEPTH = 2**ADDR_WIDTH entries (16 by default).
- AFULL_LEVEL, 12: almost_full asserts when count >= AFULL_LEVEL. Legal range 1..DEPTH.
- AEMPTY_LEVEL, 2: almost_empty asserts when count <= AEMPTY_LEVEL. Legal range 0..DEPTH-1.
- FWFT, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- we, input, 1: write request.
- wrdata, input, DATA_SIZE: write data.
- re, input, 1: read/pop request.
- rddata, output, DATA_SIZE: read data.
- rdvalid, output, 1: rddata holds a valid word (meaning depends on mode).
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count >= AFULL_LEVEL.
- almost_empty, output, 1: count <= AEMPTY_LEVEL.
- count, output, ADDR_WIDTH+1: number of stored words, 0..DEPTH.
- overflow, output, 1: sticky; a write was attempted while full.
- underflow, output, 1: sticky; a read was attempted while empty.
- clr_err, input, 1: clears overflow and underflow.

## Operation

- **Pointers:** wp and rp are ADDR_WIDTH+1 bits wide. The low bits address storage; the MSB is the wrap bit. Both increment modulo 2**(ADDR_WIDTH+1).
- **Accepted write:** we & ~full, evaluated before the edge. On the edge, mem[wp] <= wrdata and wp increments.
- **Accepted read:** re & ~empty, evaluated before the edge. rp increments.
- **Rejected operations:** a write while full is dropped and sets overflow. A read while empty sets underflow and changes nothing else.
- **Simultaneous we & re:**
  - Neither full nor empty: both are accepted and count is unchanged.
  - When full: only the read is accepted, and overflow is set.
  - When empty: only the write is accepted, and underflow is set.
- **count:** incremented by an accepted write, decremented by an accepted read. All flags decode combinationally from registered count.
- **Error flags:**
  - Setting takes priority over clr_err in the same cycle.
  - clr_err alone clears both flags on the next edge.
- **FWFT=0 (standard read):**
  - An accepted read loads rddata <= mem[rp] on the edge, and rdvalid is 1 for exactly the following cycle.
  - Otherwise rddata holds its value and rdvalid is 0.
- **FWFT=1 (first-word-fall-through):**
  - rddata = mem[rp] combinationally and rdvalid = ~empty.
  - The head word is visible before re; re acknowledges and pops it.
  - rddata is don't-care while empty.
- **Reset (rst high at an edge), including mid-operation:**
  - wp = rp = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - rddata = 0, rdvalid = 0, overflow = underflow = 0.
  - Storage contents are not cleared but are unreachable.
  - we and re are ignored during the reset cycle.

## Timing

- **Write-to-flag latency:** 1 cycle. An accepted write at edge N drops empty after edge N.
- **Read latency, FWFT=0:** 1 cycle from the re edge to valid rddata and rdvalid.
- **Read latency, FWFT=1:**
  - A write into an empty FIFO at edge N shows the word on rddata with rdvalid = 1 after edge N.
  - A pop at edge N presents the next word after edge N.
- **Throughput:** one write and one read per cycle sustained, with no bubbles.
- **Full transition:** full asserts the cycle after the DEPTH-th accepted write and deasserts the cycle after the first accepted read.
- **Wrap-around:** addressing is continuous across the DEPTH boundary. Full and empty are unaffected by wrap because they decode from count.

## Test plan

- **Reset defaults:** reset, then idle -> count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, rdvalid = 0, rddata = 0, overflow = underflow = 0.
- **Fill, overflow and drain (defaults, FWFT=0):**
  - Write 0x00..0x0F -> almost_full rises after the 12th write and full after the 16th.
  - A 17th write with 0xAA -> dropped, overflow = 1, count = 16.
  - Read 16 words -> 0x00..0x0F, each one cycle after re.
- **Underflow and error clear:** re on an empty FIFO -> underflow = 1, count = 0, rp unchanged. Then pulse clr_err -> underflow = 0 next cycle. Then clr_err together with an illegal re -> underflow stays 1.
- **Simultaneous operations:**
  - At count = 5, 10 cycles of we & re -> count stays 5 and data order is preserved.
  - At full, we & re -> count = 15 and overflow = 1.
  - At empty, we & re -> count = 1 and underflow = 1.
- **Wrap-around and FWFT=1:**
  - Stream 40 words through with random gaps -> in-order output, rdvalid == ~empty.
  - Write 0x5A into an empty FIFO -> rddata = 0x5A with rdvalid = 1 on the next cycle, before any re.
- **Mid-operation reset:** at count = 9, assert rst for one cycle together with we & re -> count = 0, empty = 1, flags at defaults. Then a write of 0x33 followed by a read -> 0x33 is returned.

Source files
------------

// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable first-word-fall-through reads.
module fifo_flags #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_LEVEL  = 12,
  parameter int unsigned AEMPTY_LEVEL = 2,
  parameter int unsigned FWFT         = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_SIZE-1:0]  wrdata,
  input  logic                  re,
  output logic [DATA_SIZE-1:0]  rddata,
  output logic                  rdvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wp;
  logic [PTR_W-1:0]     r_rp;
  logic [PTR_W-1:0]     r_count;
  logic                 r_overflow;
  logic                 r_underflow;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic [DATA_SIZE-1:0] w_head;

  // Flags decode from the registered count, so wrap never confuses full/empty.
  assign w_full  = (r_count == PTR_W'(DEPTH));
  assign w_empty = (r_count == PTR_W'(0));
  assign w_wr_ok = we & ~w_full;
  assign w_rd_ok = re & ~w_empty;
  assign w_head  = r_mem[r_rp[ADDR_WIDTH-1:0]];

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= PTR_W'(AFULL_LEVEL));
  assign almost_empty = (r_count <= PTR_W'(AEMPTY_LEVEL));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Storage write; contents survive reset but become unreachable.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[r_wp[ADDR_WIDTH-1:0]] <= wrdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_wp <= r_wp + PTR_W'(1);
      if (w_rd_ok) r_rp <= r_rp + PTR_W'(1);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + PTR_W'(1);
        2'b01:   r_count <= r_count - PTR_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (we & w_full)      r_overflow <= 1'b1;
      else if (clr_err)     r_overflow <= 1'b0;
      if (re & w_empty)     r_underflow <= 1'b1;
      else if (clr_err)     r_underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word falls through; valid whenever something is stored.
    assign rddata  = w_head;
    assign rdvalid = ~w_empty;
  end else begin : g_std
    logic [DATA_SIZE-1:0] r_rddata;
    logic                 r_rdvalid;

    // Registered read: data lands one cycle after the accepted pop.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rddata  <= '0;
        r_rdvalid <= 1'b0;
      end else begin
        r_rdvalid <= w_rd_ok;
        if (w_rd_ok) r_rddata <= w_head;
      end
    end

    assign rddata  = r_rddata;
    assign rdvalid = r_rdvalid;
  end

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: one standard-read and one FWFT instance share the same
// stimulus and are compared every cycle against a queue-based reference.
module tb_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] wrdata = 8'h00;

  logic [7:0] rddata0, rddata1;
  logic       rdvalid0, rdvalid1;
  logic       full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1;
  logic [4:0] count0, count1;
  logic       ovf0, ovf1, udf0, udf1;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_rd  = 8'h00;
  logic       m_rdv = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  always #5 clk = ~clk;

  fifo_flags #(.DATA_SIZE(8), .ADDR_WIDTH(4), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .we(we), .wrdata(wrdata), .re(re),
    .rddata(rddata0), .rdvalid(rdvalid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0), .clr_err(clr_err)
  );

  fifo_flags #(.DATA_SIZE(8), .ADDR_WIDTH(4), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .we(we), .wrdata(wrdata), .re(re),
    .rddata(rddata1), .rdvalid(rdvalid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1), .clr_err(clr_err)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: a FIFO is a queue; flags follow from its size.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rd  = 8'h00;
      m_rdv = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      m_rdv = re && !was_empty;
      if (m_rdv) m_rd = q.pop_front();
      if (we && !was_full) q.push_back(wrdata);
      if (we && was_full) m_ovf = 1'b1;
      else if (clr_err)   m_ovf = 1'b0;
      if (re && was_empty) m_udf = 1'b1;
      else if (clr_err)    m_udf = 1'b0;
    end
  end

  // Every-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = q.size();
      chk("count0", 32'(count0), 32'(n));
      chk("count1", 32'(count1), 32'(n));
      chk("empty0", 32'(empty0), 32'(n == 0));
      chk("empty1", 32'(empty1), 32'(n == 0));
      chk("full0",  32'(full0),  32'(n == 16));
      chk("full1",  32'(full1),  32'(n == 16));
      chk("afull0", 32'(af0),    32'(n >= 12));
      chk("afull1", 32'(af1),    32'(n >= 12));
      chk("aempty0", 32'(ae0),   32'(n <= 2));
      chk("aempty1", 32'(ae1),   32'(n <= 2));
      chk("ovf0", 32'(ovf0), 32'(m_ovf));
      chk("ovf1", 32'(ovf1), 32'(m_ovf));
      chk("udf0", 32'(udf0), 32'(m_udf));
      chk("udf1", 32'(udf1), 32'(m_udf));
      chk("rdvalid0", 32'(rdvalid0), 32'(m_rdv));
      chk("rddata0",  32'(rddata0),  32'(m_rd));
      chk("rdvalid1", 32'(rdvalid1), 32'(n != 0));
      if (n != 0) chk("rddata1", 32'(rddata1), 32'(q[0]));
    end
  end

  // One clock of stimulus; returns just after the edge that consumed it.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic c, input logic rs);
    @(negedge clk);
    we = w; wrdata = d; re = r; clr_err = c; rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int written;
    // Reset defaults
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_aempty", 32'(ae0), 32'd1);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_afull", 32'(af0), 32'd0);
    chk("rst_rdvalid0", 32'(rdvalid0), 32'd0);
    chk("rst_rdvalid1", 32'(rdvalid1), 32'd0);
    chk("rst_rddata0", 32'(rddata0), 32'd0);
    chk("rst_ovf_udf", 32'({ovf0, udf0, ovf1, udf1}), 32'd0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 10) chk("afull_at11", 32'(af0), 32'd0);
      if (i == 11) chk("afull_at12", 32'(af0), 32'd1);
      if (i == 14) chk("full_at15", 32'(full0), 32'd0);
      if (i == 15) chk("full_at16", 32'(full0), 32'd1);
    end
    chk("fwft_head0", 32'(rddata1), 32'h00);
    // 17th write dropped
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf0), 32'd1);
    chk("ovf_count", 32'(count0), 32'd16);
    // Drain 16 words
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_valid", 32'(rdvalid0), 32'd1);
      chk("drain_data", 32'(rddata0), 32'(i));
      if (i == 0) chk("full_drop", 32'(full0), 32'd0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rdvalid_idle", 32'(rdvalid0), 32'd0);
    chk("rddata_hold", 32'(rddata0), 32'h0F);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", 32'(ovf0), 32'd0);

    // Underflow and error clear
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("udf_set", 32'(udf0), 32'd1);
    chk("udf_count", 32'(count0), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("udf_clr", 32'(udf0), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("udf_set_wins", 32'(udf0), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Simultaneous ops at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
    chk("simul_count", 32'(count0), 32'd5);
    chk("simul_last", 32'(rddata0), 32'h24);
    chk("simul_head1", 32'(rddata1), 32'h25);

    // Simultaneous ops at full
    for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    chk("refill_full", 32'(full0), 32'd1);
    step(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
    chk("full_simul_count", 32'(count0), 32'd15);
    chk("full_simul_ovf", 32'(ovf0), 32'd1);
    chk("full_simul_rd", 32'(rddata0), 32'h25);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Simultaneous ops at empty
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drained", 32'(empty0), 32'd1);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("empty_simul_count", 32'(count0), 32'd1);
    chk("empty_simul_udf", 32'(udf0), 32'd1);
    chk("empty_simul_rdv0", 32'(rdvalid0), 32'd0);
    chk("empty_simul_fwft", 32'(rddata1), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Stream 40 words with random gaps (pointers wrap several times)
    written = 0;
    for (int c = 0; c < 400 && written < 40; c++) begin
      logic w, r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (w && q.size() < 16) written++;
      step(w, 8'(8'h80 + written), r, 1'b0, 1'b0);
    end
    chk("stream_done", 32'(written), 32'd40);
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("stream_empty", 32'(empty1), 32'd1);

    // FWFT: write into empty shows immediately
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("fwft_5a_data", 32'(rddata1), 32'h5A);
    chk("fwft_5a_valid", 32'(rdvalid1), 32'd1);
    chk("std_5a_valid", 32'(rdvalid0), 32'd0);

    // Mid-operation reset at count 9
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count0), 32'd9);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    chk("mrst_count", 32'(count0), 32'd0);
    chk("mrst_empty", 32'(empty0), 32'd1);
    chk("mrst_aempty", 32'(ae0), 32'd1);
    chk("mrst_full_af", 32'({full0, af0}), 32'd0);
    chk("mrst_rd0", 32'({rdvalid0, rddata0}), 32'd0);
    chk("mrst_rdvalid1", 32'(rdvalid1), 32'd0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    chk("post_rst_fwft", 32'(rddata1), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("post_rst_data", 32'(rddata0), 32'h33);
    chk("post_rst_valid", 32'(rdvalid0), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("post_rst_empty", 32'(empty0), 32'd1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
